// File: rtl/cpu_pc_sequencer_if.sv
// Sequencer-side view of the controller handshake: next-PC select, qualifiers,
// interrupt request, and the PC/IFF/stack status returned to the controller.
interface cpu_pc_sequencer_if #(
    parameter int PC_W = 16
);
    logic            en;
    logic [1:0]      SPC;
    logic            call;
    logic            reti;
    logic [PC_W-1:0] target;
    logic            ei;
    logic            di;
    logic            irq_req;
    logic            clr_err;
    logic [PC_W-1:0] PC;
    logic            IFF;
    logic            irq_ack;
    logic            stack_empty;
    logic            stack_full;
    logic            ovf_err;
    logic            unf_err;

    modport master (
        output en, SPC, call, reti, target, ei, di, irq_req, clr_err,
        input  PC, IFF, irq_ack, stack_empty, stack_full, ovf_err, unf_err
    );

    modport slave (
        input  en, SPC, call, reti, target, ei, di, irq_req, clr_err,
        output PC, IFF, irq_ack, stack_empty, stack_full, ovf_err, unf_err
    );
endinterface

// File: rtl/cpu_pc_sequencer.sv
// Program counter, hardware return-address stack and interrupt-enable flop,
// sequenced by the controller's 2-bit next-PC select.
module cpu_pc_sequencer #(
    parameter int              PC_W        = 16,
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter logic [PC_W-1:0] IRQ_VEC     = PC_W'(4)
) (
    input logic                clk,
    input logic                rst,
    cpu_pc_sequencer_if.slave  bus
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int IX_W = SP_W - 1;

    typedef enum logic [1:0] {
        SPC_SEQ  = 2'd0,
        SPC_JMP  = 2'd1,
        SPC_RET  = 2'd2,
        SPC_SKIP = 2'd3
    } spc_e;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0] r_sp;
    logic            r_iff;
    logic            r_ack;
    logic            r_ovf;
    logic            r_unf;

    spc_e            w_spc;
    logic            w_empty;
    logic            w_full;
    logic [SP_W-1:0] w_sp_m1;
    logic [PC_W-1:0] w_top;
    logic [PC_W-1:0] w_pc_inc1;
    logic [PC_W-1:0] w_pc_inc2;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_push_data;
    logic            w_take;
    logic            w_push;
    logic            w_pop;

    assign w_spc     = spc_e'(bus.SPC);
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
    assign w_sp_m1   = r_sp - SP_W'(1);
    assign w_top     = r_stack[w_sp_m1[IX_W-1:0]];
    assign w_pc_inc1 = r_pc + PC_W'(1);
    assign w_pc_inc2 = r_pc + PC_W'(2);

    always_comb begin
        w_seq_pc = w_pc_inc1;
        unique case (w_spc)
            SPC_SEQ:  w_seq_pc = w_pc_inc1;
            SPC_JMP:  w_seq_pc = bus.target;
            SPC_RET:  w_seq_pc = w_empty ? w_pc_inc1 : w_top;
            SPC_SKIP: w_seq_pc = w_pc_inc2;
        endcase
        // Calls and returns already own the stack this cycle, so they defer the interrupt.
        w_take      = bus.en & bus.irq_req & r_iff
                    & ~((w_spc == SPC_JMP) & bus.call) & (w_spc != SPC_RET);
        w_push      = bus.en & (((w_spc == SPC_JMP) & bus.call) | w_take);
        w_push_data = w_take ? w_seq_pc : w_pc_inc1;
        w_pop       = bus.en & (w_spc == SPC_RET);
        w_pc_next   = w_take ? IRQ_VEC : w_seq_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= RESET_VEC;
            r_sp  <= '0;
            r_iff <= 1'b0;
            r_ack <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ack <= w_take;
            if (bus.en) begin
                r_pc <= w_pc_next;
            end
            if (w_push && !w_full) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop && !w_empty) begin
                r_sp <= w_sp_m1;
            end
            if (w_take || bus.di) begin
                r_iff <= 1'b0;
            end else if (bus.ei || (w_pop && bus.reti)) begin
                r_iff <= 1'b1;
            end
            r_ovf <= (w_push & w_full)  | (r_ovf & ~bus.clr_err);
            r_unf <= (w_pop  & w_empty) | (r_unf & ~bus.clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_full) begin
            r_stack[r_sp[IX_W-1:0]] <= w_push_data;
        end
    end

    assign bus.PC          = r_pc;
    assign bus.IFF         = r_iff;
    assign bus.irq_ack     = r_ack;
    assign bus.stack_empty = w_empty;
    assign bus.stack_full  = w_full;
    assign bus.ovf_err     = r_ovf;
    assign bus.unf_err     = r_unf;
endmodule

// File: doc/cpu_pc_sequencer.md
Name: cpu_pc_sequencer

Overview:
- Program-counter and sequencing stage directly downstream of the instruction controller.
- Consumes the controller's 2-bit SPC next-PC select, plus call/return qualifiers and the branch target.
- Holds the PC, a hardware return-address stack and the interrupt-enable flip-flop (IFF).
- IFF feeds back into the controller's conditional decode.

Parameters:
- PC_W, 16, PC and target width.
- STACK_DEPTH, 8, return-stack entries (power of two, >=2).
- RESET_VEC, 16'h0000, PC value after reset.
- IRQ_VEC, 16'h0004, interrupt entry address.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance strobe (1 = instruction retires this cycle; 0 = stall).
- SPC  in  2  next-PC select from controller.
- call  in  1  push return address (valid only with SPC=1).
- reti  in  1  return-from-interrupt qualifier (valid only with SPC=2).
- target  in  PC_W  jump/branch target.
- ei  in  1  set IFF.
- di  in  1  clear IFF.
- irq_req  in  1  level interrupt request.
- clr_err  in  1  clear sticky error flags.
- PC  out  PC_W  current program counter.
- IFF  out  1  interrupt enable flip-flop.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- stack_empty  out  1  stack pointer = 0.
- stack_full  out  1  stack pointer = STACK_DEPTH.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset values (asynchronous, immediate on rst=1): PC=RESET_VEC, IFF=0, irq_ack=0, sp=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0. Stack RAM contents are don't-care.
- en=0: PC, sp, stack, IFF all hold. irq_req is not sampled. irq_ack=0. ei/di/clr_err are still honoured.
- en=1, SPC decode (single-cycle; new PC visible the cycle after the edge):
  - 0: PC <= PC+1.
  - 1: PC <= target. If call=1, push PC+1 first.
  - 2: PC <= top of stack, sp decrements. If reti=1, also IFF <= 1.
  - 3: PC <= PC+2 (skip next word).
- Arithmetic: PC_W-bit unsigned, wraps modulo 2^PC_W (e.g. 16'hFFFF + 2 = 16'h0001).
- Interrupt entry, taken when en=1 AND irq_req=1 AND IFF=1 (registered value) AND NOT (SPC=1 with call=1) AND NOT (SPC=2):
  - Push the PC this instruction would otherwise have produced.
  - PC <= IRQ_VEC, IFF <= 0, irq_ack=1 for exactly one cycle.
  - Blocked cycles defer the interrupt to the next eligible en=1 cycle.
- IFF update priority, highest first: interrupt entry clears; then di clears; then ei/reti sets. ei and di together: di wins. ei affects interrupt eligibility from the following cycle only.
- Push while full: entry dropped, sp unchanged, ovf_err <= 1. The PC update proceeds normally.
- Pop while empty: PC <= PC+1, sp stays 0, unf_err <= 1.
- Error flags clear only on rst or clr_err=1. A set event in the same cycle as clr_err wins (flag ends 1).
- stack_empty and stack_full are combinational decodes of the registered sp.
- Reset asserted mid-operation aborts everything. There is no pending-interrupt memory beyond the irq_req level.

Test Plan:
- Reset then en=1, SPC=0 for 3 cycles -> PC 0,1,2,3; IFF=0; stack_empty=1.
- PC=16'h0010, SPC=1, call=1, target=16'h0100, then SPC=2 -> PC=16'h0100, then 16'h0011; sp 1 then 0.
- ei=1; next cycle PC=16'h0020, SPC=0, irq_req=1 -> PC=16'h0004, irq_ack pulse, IFF=0. Then SPC=2, reti=1 -> PC=16'h0021, IFF=1.
- Nine calls with STACK_DEPTH=8 -> stack_full after 8th, ovf_err=1 after 9th. Pop on empty -> PC+1, unf_err=1. clr_err=1 -> both flags 0.
- irq_req=1, IFF=1 with SPC=1, call=1 -> no irq_ack. Next en=1 cycle with SPC=0 -> irq taken, two stack entries present.
- en=0 with irq_req=1, SPC=1 for 4 cycles -> PC frozen, irq_ack=0. Assert rst mid-sequence -> PC=RESET_VEC immediately, sp=0.
